// File: rtl/led_game_pkg.sv
// Shared constants and FSM encoding for the LED game
// switch front end.
package led_game_pkg;

  localparam int SWITCH_WIDTH = 10;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_HOLD     = 8;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HOLD = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/switch_capture_if.sv
// Switch-side bundle: raw board levels in, clean
// one-hot press events and status out.
interface switch_capture_if
  import led_game_pkg::*;
#(
  parameter int WIDTH = SWITCH_WIDTH
);

  logic [WIDTH-1:0] raw_switch;
  logic [WIDTH-1:0] switch_out;
  logic             press_valid;
  logic             multi_err;
  logic [7:0]       press_count;

  modport master (
    input  raw_switch,
    output switch_out,
    output press_valid,
    output multi_err,
    output press_count
  );

  modport slave (
    output raw_switch,
    input  switch_out,
    input  press_valid,
    input  multi_err,
    input  press_count
  );

endinterface

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchroniser followed by a
// stable-count debouncer.
module switch_debounce
  import led_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any return to the old level restarts the count
      if (s2 != stable) begin
        if (cnt == LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_capture.sv
// Debounces all switches and turns a single new press
// into a fixed-length one-hot pulse for the game engine.
module switch_capture
  import led_game_pkg::*;
#(
  parameter int WIDTH           = SWITCH_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int HOLD_CYCLES     = DEF_HOLD
) (
  input  logic      clock,
  input  logic      reset_n,
  switch_capture_if.master bus
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic             one_hot;
  logic             multi;

  cap_state_t       state;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] sw;
  logic             valid;
  logic             err;
  logic [7:0]       count;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (bus.raw_switch[i]),
      .stable (stable[i])
    );
  end

  assign rise    = stable & ~stable_d;
  assign one_hot = (rise != '0) &&
                   ((rise & (rise - WIDTH'(1))) == '0);
  assign multi   = (rise != '0) && !one_hot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CAP_IDLE;
      stable_d <= '0;
      hold_cnt <= '0;
      sw       <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      stable_d <= stable;
      err      <= 1'b0;
      unique case (state)
        CAP_IDLE: begin
          if (one_hot) begin
            sw       <= rise;
            valid    <= 1'b1;
            hold_cnt <= '0;
            if (count != 8'hFF) count <= count + 8'd1;
            state    <= CAP_HOLD;
          end else if (multi) begin
            err <= 1'b1;
          end
        end
        CAP_HOLD: begin
          if (hold_cnt == HLAST) begin
            sw    <= '0;
            valid <= 1'b0;
            state <= CAP_WAIT;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        // a held switch must fully release before re-arming
        CAP_WAIT: begin
          if (stable == '0) state <= CAP_IDLE;
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

  assign bus.switch_out  = sw;
  assign bus.press_valid = valid;
  assign bus.multi_err   = err;
  assign bus.press_count = count;

endmodule
